// File: rtl/input_dma_controller.sv
// rtl/input_dma_controller.sv - debounced button snapshot DMA into data memory
`ifndef KEY_MEM
`define KEY_MEM 'h100
`endif
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 16
`endif

module input_dma_controller #(
    parameter int BUTTON_COUNT    = 16,
    parameter int BASE_ADDR       = `KEY_MEM,
    parameter int ADDR_WIDTH      = `DATA_ADDR_WIDTH,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    copy_start,
    input  logic [1:0]              mode,
    input  logic [BUTTON_COUNT-1:0] buttons_in,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [15:0]             mem_dout
);

    localparam int W      = (BUTTON_COUNT + 15) / 16;
    localparam int PADDED = W * 16;

    typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

    state_t                  state, state_next;
    logic [BUTTON_COUNT-1:0] sync1, sync2, level, level_next, pressed, released;
    logic [PADDED-1:0]       snap_level, snap_pressed, snap_released;
    logic [1:0]              mode_q;
    logic [7:0]              idx, k;
    logic                    accept;

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodb
            assign level_next = sync2;
        end else begin : g_db
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
            logic [CW-1:0] cnt [BUTTON_COUNT];

            // The level flips on the edge where the count would reach DEBOUNCE_CYCLES.
            always_comb begin
                level_next = level;
                for (int i = 0; i < BUTTON_COUNT; i++) begin
                    if (sync2[i] != level[i] && cnt[i] == LAST) begin
                        level_next[i] = sync2[i];
                    end
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < BUTTON_COUNT; i++) begin
                    if (reset || sync2[i] == level[i] || cnt[i] == LAST) begin
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign accept = (state == IDLE) && copy_start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            sync1         <= '0;
            sync2         <= '0;
            level         <= '0;
            pressed       <= '0;
            released      <= '0;
            snap_level    <= '0;
            snap_pressed  <= '0;
            snap_released <= '0;
            mode_q        <= 2'd0;
            idx           <= 8'd0;
        end else begin
            state    <= state_next;
            sync1    <= buttons_in;
            sync2    <= sync1;
            level    <= level_next;
            // A transition on the accept edge survives the clear and goes to the next burst.
            pressed  <= (accept ? '0 : pressed)  | (level_next & ~level);
            released <= (accept ? '0 : released) | (~level_next & level);
            if (accept) begin
                snap_level    <= PADDED'(level);
                snap_pressed  <= PADDED'(pressed);
                snap_released <= PADDED'(released);
                mode_q        <= (mode == 2'd3) ? 2'd0 : mode;
                idx           <= 8'd0;
            end else if (state == COPY) begin
                idx <= idx + 8'd1;
            end
        end
    end

    always_comb begin
        case (mode_q)
            2'd1:    k = 8'(W);
            2'd2:    k = 8'(3 * W);
            default: k = 8'(BUTTON_COUNT);
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = COPY;
            COPY:    if (idx == k - 8'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic [PADDED-1:0] sel_vec, shifted;
    logic [7:0]        slot;
    logic [15:0]       word;

    always_comb begin
        sel_vec = snap_level;
        slot    = idx;
        if (mode_q == 2'd2) begin
            if (idx >= 8'(2 * W)) begin
                sel_vec = snap_released;
                slot    = idx - 8'(2 * W);
            end else if (idx >= 8'(W)) begin
                sel_vec = snap_pressed;
                slot    = idx - 8'(W);
            end
        end
        if (mode_q == 2'd0) begin
            shifted = sel_vec >> idx;
            word    = {16{shifted[0]}};
        end else begin
            shifted = sel_vec >> {slot, 4'b0000};
            word    = shifted[15:0];
        end
    end

    always_comb begin
        busy     = (state == COPY);
        mem_we   = (state == COPY);
        done     = (state == DONE);
        mem_addr = ADDR_WIDTH'(BASE_ADDR);
        mem_dout = 16'h0000;
        if (state == COPY) begin
            mem_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx);
            mem_dout = word;
        end
    end

endmodule

// File: doc/input_dma_controller.md
Name: input_dma_controller

Overview:
- Parametrised successor of the single-mode DMA button controller.
- Debounces BUTTON_COUNT asynchronous inputs and tracks sticky press/release events.
- On copy_start, snapshots the state and burst-writes it into data memory in one of three layouts: one word per button, packed levels, or packed levels plus event words.
- Sits beside the CPU and owns the data-memory write port only while busy is high.

Parameters:
- BUTTON_COUNT, 16, number of inputs (1..64).
- BASE_ADDR, `KEY_MEM, first data-memory word written.
- ADDR_WIDTH, `DATA_ADDR_WIDTH, memory address width.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to change a debounced level; 0 means no debounce.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- copy_start  in  1  request one copy burst; sampled every cycle.
- mode  in  2  layout select, latched when a request is accepted: 0 = per-word, 1 = packed, 2 = packed+events, 3 = treated as 0.
- buttons_in  in  BUTTON_COUNT  raw asynchronous inputs; bit i is button i.
- busy  out  1  high while the burst is in progress.
- done  out  1  one-cycle pulse after the last write.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_dout  out  16  write data.

Behaviour:
- Reset values:
  - busy=0, done=0, mem_we=0, mem_addr=BASE_ADDR, mem_dout=0.
  - All debounced levels, sticky flags and snapshot registers = 0.
  - Debounce counters = 0; state IDLE.
- Input path:
  - Each input passes through a 2-flop synchroniser, then a per-button debounce counter.
  - The counter increments while the synchronised value differs from the debounced level and clears to 0 when they match.
  - When the count reaches DEBOUNCE_CYCLES, the level flips and the counter clears.
  - With DEBOUNCE_CYCLES=0, the level equals the synchroniser output.
  - Minimum raw-to-level latency = 2 + DEBOUNCE_CYCLES cycles.
- Sticky flags:
  - pressed[i] is set on a debounced 0->1 transition; released[i] is set on a 1->0 transition.
  - Both stay set until captured.
- Request acceptance:
  - copy_start is accepted only in IDLE. It is ignored while busy or in the done cycle; there is no queueing.
- Acceptance cycle T:
  - Snapshot the levels, pressed and released bits, and mode.
  - Clear the sticky flags. A transition detected in cycle T sets its flag after the clear (set wins) and is reported in the next burst, not this one.
- Word count K, with W = ceil(BUTTON_COUNT/16):
  - mode 0: K = BUTTON_COUNT.
  - mode 1: K = W.
  - mode 2: K = 3W.
- States and transitions:
  - IDLE -> COPY on accept.
  - COPY -> DONE after word K-1 is written.
  - DONE -> IDLE unconditionally.
- COPY timing:
  - Occupies cycles T+1 .. T+K, with mem_we=1 and busy=1 in each.
  - Word j is presented in cycle T+1+j at mem_addr = BASE_ADDR + j, arithmetic modulo 2^ADDR_WIDTH.
- DONE cycle T+K+1: done=1, busy=0, mem_we=0, mem_addr returns to BASE_ADDR.
- Layouts:
  - mode 0: word j = {16{level[j]}}.
  - mode 1: word j bit b = level[16j+b].
  - mode 2: words 0..W-1 are levels as in mode 1; words W..2W-1 are pressed flags; words 2W..3W-1 are released flags, all in the same bit mapping.
  - In packed words, bits for indices ≥ BUTTON_COUNT are 0.
- mem_dout is don't-care when mem_we=0 and is driven to 0.
- Reset mid-burst: on the next edge, mem_we=0 and busy=0, no done pulse, all state cleared; the remaining words are never written.
- mode changes during a burst have no effect.

Test Plan:
- Reset, hold buttons_in=0x0005, wait 10 cycles, pulse copy_start with mode=0 (N=16, BASE=0x100) -> 16 writes at 0x100..0x10F; 0x100 and 0x102 = 0xFFFF, the rest 0x0000; done pulses at T+17.
- Same levels with mode=1 -> exactly one write, 0x100 = 0x0005; busy high for 1 cycle; done at T+2.
- N=20, press buttons 3 and 17, release 3, then mode=2 -> 6 writes:
  - levels 0x0000 / 0x0002
  - pressed 0x0008 / 0x0002
  - released 0x0008 / 0x0000
  - a second immediate mode=2 copy -> pressed and released words all 0.
- DEBOUNCE_CYCLES=4, glitch button 0 high for 3 cycles -> level stays 0 and pressed stays 0; hold high for 6 cycles -> level becomes 1 at cycle 6 after the raw edge.
- copy_start held high for 20 cycles with mode=0, N=16 -> bursts start at T and T+18, and no copy_start is accepted during busy or done.
- Assert reset at the 5th write of a mode 0 burst -> mem_we=0 from the next cycle, no done pulse, and a following copy writes all levels 0 from BASE_ADDR.
